bitty_sequencer: RTL
====================

# bitty_sequencer

Program sequencer for the bitty core. It holds a small instruction buffer loaded over a write port. On `start` it releases the core from reset, issues `run`, and feeds `d_instr` one instruction per core cycle, advancing on each core `done`. It streams every instruction result out with an index, then parks the core in reset again.

## Interface
Parameters:
- `DEPTH`, default 16: instruction buffer entries (power of two, ≥2).
- `AW`, default $clog2(DEPTH): buffer address width.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-high.
- `prog_we`  in  1  Buffer write strobe; ignored while `busy`.
- `prog_addr`  in  AW  Buffer write address.
- `prog_data`  in  16  Instruction word to write.
- `prog_len`  in  AW+1  Instruction count, sampled on accepted `start`; values >DEPTH saturate to DEPTH.
- `start`  in  1  Begin execution; honoured only in IDLE.
- `abort`  in  1  Stop execution; honoured in LAUNCH/RUN/FINISH.
- `busy`  out  1  High in any state other than IDLE.
- `core_rst`  out  1  Reset to the core. Registered and glitch-free, because the core reset is asynchronous.
- `run`  out  1  Run request to the core.
- `d_instr`  out  16  Instruction to the core.
- `core_done`  in  1  Core `done` (WRITEBACK cycle).
- `core_dout`  in  16  Core `d_out`.
- `res_valid`  out  1  Per-instruction result strobe.
- `res_idx`  out  AW  Index of the instruction whose result is on `res_data`.
- `res_data`  out  16  Equals `core_dout`; meaningful only when `res_valid`.
- `last_result`  out  16  Result of the final instruction; holds until the next accepted `start`.
- `prog_done`  out  1  One-cycle pulse: program completed.
- `aborted`  out  1  One-cycle pulse: execution aborted.

## Operation
States:
- **IDLE**
  - `core_rst`=1, `run`=0, `d_instr`=0.
  - Buffer writes accepted.
  - `start` with effective length N≥1 → LAUNCH. Effective length is latched and `pc` is set to 0.
  - `start` with N=0 → `prog_done` pulse next cycle; the state stays IDLE and no launch occurs.
- **LAUNCH** (exactly one cycle)
  - `core_rst`=0, `run`=1, `d_instr`=buf[0].
  - → RUN.
- **RUN**
  - `run`=0 and `d_instr`=buf[pc], driven combinationally from registered `pc`.
  - On `core_done` with pc<N-1: `pc` increments, and `res_valid`/`res_idx`=pc are registered for the next cycle.
  - On `core_done` with pc=N-1: → FINISH, with `res_valid` registered as above. `pc` does not increment.
- **FINISH** (one cycle)
  - `res_valid`=1; `last_result` captures `core_dout`; `prog_done`=1.
  - → IDLE, so `core_rst` is reasserted on the following cycle.

Other rules:
- `abort` in LAUNCH/RUN/FINISH → IDLE next cycle and `aborted` pulses. No `prog_done` is emitted and `last_result` is unchanged. A `res_valid` already registered for that cycle still appears.
- `abort` and `start` in the same cycle while in IDLE: `start` wins and `abort` is ignored.
- `core_done` outside RUN is ignored.
- `prog_we` while `busy` is dropped; the buffer is unchanged.
- The buffer is not reset. Its contents survive `reset`.

Reset values:
- `core_rst`=1.
- `busy`, `run`, `res_valid`, `prog_done`, `aborted` = 0.
- `d_instr`, `res_idx`, `last_result`, `pc` = 0.
- State = IDLE.
- Reset mid-run returns to IDLE immediately and the core is held in reset.

## Timing
Core contract:
- `run` seen in the core's IDLE state → FETCH next cycle, which samples `d_instr`.
- FETCH → EXECUTE → WRITEBACK (`done`=1) → FETCH.
- The core's `d_out` is updated at the end of WRITEBACK.

Cycle schedule, with `start` accepted in cycle t:
- LAUNCH occupies t+1.
- Core FETCH of instruction i at t+2+3i; `core_done` for instruction i at t+4+3i.
- `res_valid` for instruction i at t+5+3i. This coincides with FETCH of instruction i+1, with `d_instr`=buf[i+1] already stable.
- Last instruction: FINISH, `prog_done` and `res_valid` all at t+2+3N; IDLE and `core_rst`=1 from t+3+3N.
- Total latency from `start` to `prog_done` is 3N+2 cycles.
- The next `start` is accepted at t+3+3N at the earliest.

## Test plan
- **Load and run 3 instructions.** Load buf = {0x0000, 0x0000, 0x0002} (inc r0, inc r0, not r0), prog_len=3, `start` at t.
  - `run` high at t+1 only.
  - `res_valid` at t+5/t+8/t+11 with `res_idx` 0/1/2 and `res_data` 0x0001/0x0002/0xFFFD.
  - `prog_done` and `last_result`=0xFFFD at t+11; `core_rst`=1 at t+12.
- **Zero-length program.** prog_len=0, `start` → `prog_done` the next cycle; `run`, `busy` and `res_valid` never assert; `core_rst` stays 1.
- **Length saturation.** DEPTH=16, prog_len=20 → exactly 16 `res_valid` pulses with `res_idx` 0..15, then `prog_done` at t+50.
- **Abort.** Same program as the first test, `abort` at t+6.
  - `busy`=0 and `core_rst`=1 at t+7, `aborted` pulse at t+7.
  - No further `res_valid`; `last_result` unchanged; no `prog_done`.
- **Write and start while busy.** `prog_we` to addr 1 with 0x0006 at t+3, and `start` at t+4.
  - Both are ignored; results match the first test.
  - After completion, buf[1] still reads as 0x0000 on a rerun.
- **Asynchronous reset mid-run.** `reset` asserted between edges at t+7.
  - `core_rst`=1 and `busy`=0 immediately; all strobes 0.
  - A subsequent `start` runs the unchanged buffer and reproduces the first test's results.

Source files
------------

// File: rtl/bitty_sequencer_if.sv
// Host/core-facing signal bundle for bitty_sequencer.
// The slave modport is the sequencer's view; the master modport is the host/core side.
interface bitty_sequencer_if #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          abort;
  logic          busy;
  logic          core_rst;
  logic          run;
  logic [15:0]   d_instr;
  logic          core_done;
  logic [15:0]   core_dout;
  logic          res_valid;
  logic [AW-1:0] res_idx;
  logic [15:0]   res_data;
  logic [15:0]   last_result;
  logic          prog_done;
  logic          aborted;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len, start, abort, core_done, core_dout,
    input  busy, core_rst, run, d_instr, res_valid, res_idx, res_data, last_result,
           prog_done, aborted
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, start, abort, core_done, core_dout,
    output busy, core_rst, run, d_instr, res_valid, res_idx, res_data, last_result,
           prog_done, aborted
  );
endinterface

// File: rtl/bitty_sequencer.sv
// Program sequencer: feeds a buffered instruction stream to the bitty core,
// one instruction per core done, and streams indexed results back out.
module bitty_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  bitty_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_FINISH} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_t        state_q;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] pc_q;
  logic [AW:0]   len_q;
  logic          core_rst_q, run_q, res_valid_q, prog_done_q, aborted_q;
  logic [AW-1:0] res_idx_q;
  logic [15:0]   last_q;

  logic [AW:0]   len_d;
  logic          pc_last;
  logic          fin_abort;

  assign len_d     = (bus.prog_len > DEPTH_W) ? DEPTH_W : bus.prog_len;
  assign pc_last   = ({1'b0, pc_q} == (len_q - ONE_W));
  assign fin_abort = (state_q == S_FINISH) && bus.abort;

  // Buffer has no reset so a loaded program survives a sequencer reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we && state_q == S_IDLE)
      mem_q[bus.prog_addr] <= bus.prog_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      len_q       <= '0;
      core_rst_q  <= 1'b1;
      run_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      last_q      <= '0;
      prog_done_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      run_q       <= 1'b0;
      res_valid_q <= 1'b0;
      prog_done_q <= 1'b0;
      aborted_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start) begin
          if (len_d == '0) begin
            prog_done_q <= 1'b1;
          end else begin
            state_q    <= S_LAUNCH;
            len_q      <= len_d;
            pc_q       <= '0;
            core_rst_q <= 1'b0;
            run_q      <= 1'b1;
          end
        end
        S_LAUNCH: state_q <= S_RUN;
        S_RUN: if (bus.core_done) begin
          res_valid_q <= 1'b1;
          res_idx_q   <= pc_q;
          if (pc_last) begin
            state_q     <= S_FINISH;
            prog_done_q <= 1'b1;
          end else begin
            pc_q <= pc_q + AW'(1);
          end
        end
        S_FINISH: begin
          last_q     <= bus.core_dout;
          state_q    <= S_IDLE;
          core_rst_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
      // Abort overrides whatever the state decided this cycle.
      if (bus.abort && state_q != S_IDLE) begin
        state_q     <= S_IDLE;
        core_rst_q  <= 1'b1;
        aborted_q   <= 1'b1;
        run_q       <= 1'b0;
        res_valid_q <= 1'b0;
        prog_done_q <= 1'b0;
        last_q      <= last_q;
      end
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.core_rst  = core_rst_q;
  assign bus.run       = run_q;
  assign bus.d_instr   = (state_q == S_IDLE) ? 16'h0000 : mem_q[pc_q];
  assign bus.res_valid = res_valid_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.res_data  = bus.core_dout;
  // The final result only lands on core_dout during FINISH, so expose it directly then.
  assign bus.last_result = (state_q == S_FINISH && !bus.abort) ? bus.core_dout : last_q;
  assign bus.prog_done   = prog_done_q && !fin_abort;
  assign bus.aborted     = aborted_q;
endmodule
